// File: rtl/window_stream_buffer.sv
// Sliding-window generator: K-1 line memories and a KxK tap array turn a raster
// stream into one border-masked KxK neighbourhood per frame pixel.
module window_stream_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int WIN_SIZE     = 3,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     en,
  input  logic                                     vsync,
  input  logic [DATA_WIDTH-1:0]                    data_in,
  input  logic [1:0]                               border_mode,
  input  logic [DATA_WIDTH-1:0]                    border_value,
  output logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0]  window,
  output logic                                     window_valid,
  output logic [15:0]                              x_out,
  output logic [15:0]                              y_out,
  output logic                                     frame_done,
  output logic                                     overrun
);
  localparam int K        = WIN_SIZE;
  localparam int R        = (WIN_SIZE - 1) / 2;
  localparam int W        = FRAME_WIDTH;
  localparam int H        = FRAME_HEIGHT;
  localparam int FILL_LEN = R * W + R;
  localparam int LAST_PIX = W * H - 1;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     line_mem  [K-1][DEPTH];
  logic [DATA_WIDTH-1:0]     taps      [K][K];
  logic [DATA_WIDTH-1:0]     next_taps [K][K];
  logic [DATA_WIDTH-1:0]     column    [K];
  logic [DATA_WIDTH-1:0]     in_pix;
  logic [DATA_WIDTH-1:0]     pad_value;
  logic [K*K*DATA_WIDTH-1:0] masked;
  logic [ADDR_WIDTH-1:0]     in_x;
  logic [ADDR_WIDTH-1:0]     wr_x;
  logic [ADDR_WIDTH-1:0]     in_x_next;
  logic [31:0]               in_idx;
  logic [15:0]               cx;
  logic [15:0]               cy;
  logic                      advance;
  logic                      emit;
  logic                      last_center;

  // A vsync restarts at column 0 and may carry pixel 0 of the new frame with it.
  always_comb begin
    advance     = vsync ? en : ((((state == FILL) || (state == RUN)) && en) || (state == FLUSH));
    emit        = !vsync && advance && ((state == RUN) || (state == FLUSH));
    wr_x        = vsync ? '0 : in_x;
    in_x_next   = (in_x == ADDR_WIDTH'(W - 1)) ? '0 : in_x + ADDR_WIDTH'(1);
    in_pix      = ((state == FLUSH) && !vsync) ? '0 : data_in;
    last_center = (cx == 16'(W - 1)) && (cy == 16'(H - 1));
    pad_value   = (border_mode == 2'd1) ? border_value : '0;
  end

  // Tap (i,j) of the window being completed sources column (cx+j-R), row (cy+i-R).
  always_comb begin
    int sx;
    int sy;
    sx = 0;
    sy = 0;
    masked = '0;
    column[K-1] = in_pix;
    for (int i = 0; i < K - 1; i++)
      column[i] = line_mem[K-2-i][wr_x];
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++)
        next_taps[i][j] = taps[i][j+1];
      next_taps[i][K-1] = column[i];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        sx = int'(cx) + j - R;
        sy = int'(cy) + i - R;
        if ((border_mode != 2'd2) && ((sx < 0) || (sx >= W) || (sy < 0) || (sy >= H)))
          masked[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = pad_value;
        else
          masked[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = next_taps[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      line_mem[0][wr_x] <= in_pix;
      for (int k = 1; k < K - 1; k++)
        line_mem[k][wr_x] <= line_mem[k-1][wr_x];
    end
  end

  // Input side counts accepted pixels; output side walks the window centers in raster order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_x         <= '0;
      in_idx       <= '0;
      cx           <= '0;
      cy           <= '0;
      window       <= '0;
      window_valid <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          taps[i][j] <= '0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && last_center;
      overrun      <= vsync && (state != IDLE);
      if (advance)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            taps[i][j] <= next_taps[i][j];
      if (emit) begin
        window <= masked;
        x_out  <= cx;
        y_out  <= cy;
        if (cx == 16'(W - 1)) begin
          cx <= '0;
          cy <= cy + 16'd1;
        end else begin
          cx <= cx + 16'd1;
        end
      end
      if (vsync) begin
        state  <= FILL;
        cx     <= '0;
        cy     <= '0;
        in_x   <= en ? ADDR_WIDTH'(1) : '0;
        in_idx <= en ? 32'd1 : 32'd0;
      end else begin
        case (state)
          FILL, RUN: begin
            if (en) begin
              in_x   <= in_x_next;
              in_idx <= in_idx + 32'd1;
              if ((state == FILL) && (in_idx == 32'(FILL_LEN - 1)))
                state <= RUN;
              if ((state == RUN) && (in_idx == 32'(LAST_PIX)))
                state <= FLUSH;
            end
          end
          FLUSH: begin
            in_x <= in_x_next;
            if (last_center)
              state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_stream_buffer.sv
// Self-checking bench for window_stream_buffer: directed frames with random pixel
// data, every emitted window compared against a coordinate-level neighbourhood model.
module tb_window_stream_buffer;
  localparam int DW       = 8;
  localparam int K        = 3;
  localparam int R        = 1;
  localparam int W        = 8;
  localparam int H        = 4;
  localparam int AW       = 3;
  localparam int WW       = K * K * DW;
  localparam int NPIX     = W * H;
  localparam int FILL_LEN = R * W + R;

  typedef logic [DW-1:0] frame_t [NPIX];
  typedef int stamp_t [NPIX];
  typedef struct {
    logic [WW-1:0] w;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          fd;
    int            stamp;
  } win_rec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          vsync;
  logic [DW-1:0] data_in;
  logic [1:0]    border_mode;
  logic [DW-1:0] border_value;
  logic [WW-1:0] window;
  logic          window_valid;
  logic [15:0]   x_out;
  logic [15:0]   y_out;
  logic          frame_done;
  logic          overrun;

  int       cyc = 0;
  int       checks = 0;
  int       passes = 0;
  frame_t   fr;
  frame_t   old_fr;
  stamp_t   acc;
  stamp_t   old_acc;
  win_rec_t win_q[$];
  int       ovr_q[$];

  window_stream_buffer #(
    .DATA_WIDTH(DW), .WIN_SIZE(K), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .vsync(vsync), .data_in(data_in),
    .border_mode(border_mode), .border_value(border_value), .window(window),
    .window_valid(window_valid), .x_out(x_out), .y_out(y_out),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are captured on the falling edge, stamped with the cycle number.
  always @(negedge clk) begin
    if (window_valid)
      win_q.push_back('{w: window, x: x_out, y: y_out, fd: frame_done, stamp: cyc});
    if (overrun)
      ovr_q.push_back(cyc);
  end

  function automatic logic [WW-1:0] rows(input logic [DW-1:0] a0, a1, a2, b0, b1, b2,
                                         c0, c1, c2);
    return {c2, c1, c0, b2, b1, b0, a2, a1, a0};
  endfunction

  // Neighbourhood of center c straight from frame coordinates, padding outside the frame.
  function automatic logic [WW-1:0] model_window(input frame_t f, input int c,
                                                 input logic [1:0] mode,
                                                 input logic [DW-1:0] bval);
    logic [WW-1:0] w;
    int cx;
    int cy;
    int sx;
    int sy;
    w  = '0;
    cx = c % W;
    cy = c / W;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        sx = cx + j - R;
        sy = cy + i - R;
        if (sx >= 0 && sx < W && sy >= 0 && sy < H)
          w[(i*K+j)*DW +: DW] = f[sy*W+sx];
        else
          w[(i*K+j)*DW +: DW] = (mode == 2'd1) ? bval : '0;
      end
    end
    return w;
  endfunction

  task automatic check_output(input string tag, input logic [WW-1:0] obs,
                              input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check_output(tag, WW'(obs), WW'(exp));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, "_window"}, window, '0);
    check_int({tag, "_valid"}, int'(window_valid), 0);
    check_int({tag, "_x"}, int'(x_out), 0);
    check_int({tag, "_y"}, int'(y_out), 0);
    check_int({tag, "_done"}, int'(frame_done), 0);
    check_int({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Window for center c completes when pixel c+R*W+R advances; flush advances once per clock.
  task automatic check_windows(input frame_t f, input stamp_t a, input int first_c,
                               input int count, input logic [1:0] mode,
                               input logic [DW-1:0] bval);
    win_rec_t r;
    int c;
    int exp_stamp;
    for (int k = 0; k < count; k++) begin
      c = first_c + k;
      if (win_q.size() == 0) begin
        check_int("window_present", win_q.size(), count - k);
        return;
      end
      r = win_q.pop_front();
      check_output("window_taps", r.w, model_window(f, c, mode, bval));
      check_int("center_x", int'(r.x), c % W);
      check_int("center_y", int'(r.y), c / W);
      check_int("frame_done", int'(r.fd), int'(c == NPIX - 1));
      if (c + FILL_LEN <= NPIX - 1)
        exp_stamp = a[c + FILL_LEN] + 1;
      else
        exp_stamp = a[NPIX-1] + 1 + (c + FILL_LEN - (NPIX - 1));
      check_int("window_cycle", r.stamp, exp_stamp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    en      = e;
    vsync   = v;
    data_in = d;
  endtask

  task automatic apply_stimulus(input int gap, input int npix, input bit rnd,
                                input bit vs_with_first);
    if (!vs_with_first)
      drive(1'b0, 1'b1, 8'h00);
    for (int n = 0; n < npix; n++) begin
      fr[n] = rnd ? 8'($urandom) : 8'(n);
      drive(1'b1, vs_with_first && (n == 0), fr[n]);
      acc[n] = cyc;
      for (int g = 0; g < gap; g++)
        drive(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic idle(input int n, input logic e);
    for (int k = 0; k < n; k++)
      drive(e, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    en           = 1'b0;
    vsync        = 1'b0;
    data_in      = '0;
    border_mode  = 2'd0;
    border_value = '0;
    reset_n      = 1'b1;
    #3 reset_n = 1'b0;
    #1 check_zero_outputs("por");
    @(negedge clk) reset_n = 1'b1;

    // Zero padding, data = n, en held high through the flush to show it is ignored.
    $display("[TB] frame A: mode 0, continuous");
    apply_stimulus(0, NPIX, 1'b0, 1'b0);
    idle(15, 1'b1);
    check_int("A_count", win_q.size(), NPIX);
    if (win_q.size() == NPIX) begin
      check_output("A_first_taps", win_q[0].w,
                   rows(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd8, 8'd9));
      check_int("A_first_x", int'(win_q[0].x), 0);
      check_int("A_first_y", int'(win_q[0].y), 0);
      check_output("A_last_taps", win_q[NPIX-1].w,
                   rows(8'd22, 8'd23, 8'd0, 8'd30, 8'd31, 8'd0, 8'd0, 8'd0, 8'd0));
      check_int("A_last_x", int'(win_q[NPIX-1].x), 7);
      check_int("A_last_y", int'(win_q[NPIX-1].y), 3);
      check_int("A_last_done", int'(win_q[NPIX-1].fd), 1);
    end
    check_windows(fr, acc, 0, NPIX, 2'd0, 8'h00);
    check_int("A_overrun", ovr_q.size(), 0);

    $display("[TB] frame B: mode 1, pad 0xAA");
    border_mode  = 2'd1;
    border_value = 8'hAA;
    apply_stimulus(0, NPIX, 1'b0, 1'b0);
    idle(15, 1'b0);
    check_int("B_count", win_q.size(), NPIX);
    if (win_q.size() > 0)
      check_output("B_first_taps", win_q[0].w,
                   rows(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h01, 8'hAA, 8'h08, 8'h09));
    check_windows(fr, acc, 0, NPIX, 2'd1, 8'hAA);

    $display("[TB] frame C: mode 3, random data, en one cycle in three");
    border_mode  = 2'd3;
    border_value = 8'h55;
    apply_stimulus(2, NPIX, 1'b1, 1'b0);
    idle(15, 1'b0);
    check_int("C_count", win_q.size(), NPIX);
    check_windows(fr, acc, 0, NPIX, 2'd3, 8'h55);

    $display("[TB] restart: vsync with pixel 20");
    border_mode = 2'd0;
    apply_stimulus(0, 20, 1'b1, 1'b0);
    old_fr  = fr;
    old_acc = acc;
    apply_stimulus(0, NPIX, 1'b1, 1'b1);
    idle(15, 1'b0);
    check_int("R_count", win_q.size(), 11 + NPIX);
    check_windows(old_fr, old_acc, 0, 11, 2'd0, 8'h00);
    check_windows(fr, acc, 0, NPIX, 2'd0, 8'h00);
    check_int("R_overrun_count", ovr_q.size(), 1);
    if (ovr_q.size() > 0)
      check_int("R_overrun_cycle", ovr_q[0], acc[0] + 1);

    $display("[TB] asynchronous reset mid-frame");
    ovr_q.delete();
    apply_stimulus(0, 15, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    check_windows(fr, acc, 0, 6, 2'd0, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    idle(10, 1'b1);
    check_int("post_reset_silence", win_q.size(), 0);
    apply_stimulus(0, NPIX, 1'b0, 1'b0);
    idle(15, 1'b0);
    check_int("D_count", win_q.size(), NPIX);
    if (win_q.size() > 0)
      check_output("D_first_taps", win_q[0].w,
                   rows(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd8, 8'd9));
    check_windows(fr, acc, 0, NPIX, 2'd0, 8'h00);
    check_int("D_overrun", ovr_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
